// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b (LSB first) behind an IDLE/BUSY/DONE handshake.
// Revision 1.0
`default_nettype none

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_t;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  // Two cascaded half-subtractors on the current LSB.
  always_comb begin
    w_t        = r_a_sr[0] ^ r_b_sr[0];
    w_d        = w_t ^ r_borrow;
    w_bout     = (~r_a_sr[0] & r_b_sr[0]) | (~w_t & r_borrow);
    w_res_next = {w_d, r_res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          // The last bit goes straight to the outputs so diff never shows partials.
          if (r_cnt == LAST) begin
            diff       <= w_res_next;
            borrow_out <= w_bout;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
